// File: rtl/keypad_bcd_pkg.sv
// Shared constants and FSM state encoding for the keypad BCD encoder.
package keypad_bcd_pkg;

  localparam int unsigned BCD_W    = 4;
  localparam int unsigned NUM_KEYS = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEB  = 2'd1,
    ST_HOLD = 2'd2,
    ST_REL  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_prio_enc.sv
// Combinational 10->4 priority encoder: the highest set key index wins.
// o_multi flags more than one key line set.
module bcd_prio_enc
  import keypad_bcd_pkg::*;
(
  input  logic [NUM_KEYS-1:0] i_keys,
  output logic [BCD_W-1:0]    o_code,
  output logic                o_multi
);

  logic [NUM_KEYS-1:0] w_keys_m1;

  // Later iterations override earlier ones, so the highest index wins.
  always_comb begin
    o_code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (i_keys[i]) o_code = BCD_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_keys_m1 = i_keys - {{(NUM_KEYS-1){1'b0}}, 1'b1};
  assign o_multi   = (i_keys & w_keys_m1) != '0;

endmodule

// File: rtl/keypad_bcd_encoder.sv
// Decimal keypad to BCD encoder with synchroniser, press/release debounce
// and a multi-digit entry shift register.
// Optional macro KEYPAD_BCD_MULTI_KEY_ERR_EN: adds output err; a multi-key
// press then pulses err instead of being encoded.
module keypad_bcd_encoder
  import keypad_bcd_pkg::*;
#(
  parameter  int unsigned DEB_CYC    = 4,
  parameter  int unsigned NUM_DIGITS = 4,
  localparam int unsigned NDIG_W     = $clog2(NUM_DIGITS + 1),
  localparam int unsigned DIG_W      = BCD_W * NUM_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                clr,
  output logic [BCD_W-1:0]    bcd,
  output logic                valid,
  output logic [DIG_W-1:0]    digits,
  output logic [NDIG_W-1:0]   ndig,
  output logic                busy
`ifdef KEYPAD_BCD_MULTI_KEY_ERR_EN
  ,
  output logic                err
`endif
);

  localparam int unsigned CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [NDIG_W-1:0] NDIG_MAX = NDIG_W'(NUM_DIGITS);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_key_s;
  state_t              r_state;
  logic [NUM_KEYS-1:0] r_cap;
  logic [CNT_W-1:0]    r_cnt;
  logic [BCD_W-1:0]    r_bcd;
  logic                r_valid;
  logic [DIG_W-1:0]    r_digits;
  logic [NDIG_W-1:0]   r_ndig;
`ifdef KEYPAD_BCD_MULTI_KEY_ERR_EN
  logic                r_err;
`endif

  logic [BCD_W-1:0]    w_code;
  logic                w_multi;
  logic                w_deb_done;
  logic                w_accept;

  bcd_prio_enc u_enc (
    .i_keys  (r_cap),
    .o_code  (w_code),
    .o_multi (w_multi)
  );

  // DEB_CYC-th matching sample of the captured pattern.
  assign w_deb_done = (r_state == ST_DEB) && (r_key_s == r_cap) && (r_cnt == CNT_LAST);

`ifdef KEYPAD_BCD_MULTI_KEY_ERR_EN
  assign w_accept = w_deb_done && !w_multi;
`else
  assign w_accept = w_deb_done;
`endif

  // Two-flop synchroniser for the asynchronous key lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_key_s <= '0;
    end else begin
      r_sync1 <= key;
      r_key_s <= r_sync1;
    end
  end

  // Debounce FSM with registered bcd/valid (and err) outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cap   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_valid <= 1'b0;
`ifdef KEYPAD_BCD_MULTI_KEY_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef KEYPAD_BCD_MULTI_KEY_ERR_EN
      r_err   <= 1'b0;
`endif
      unique case (r_state)
        ST_IDLE: begin
          if (r_key_s != '0) begin
            r_cap   <= r_key_s;
            r_cnt   <= '0;
            r_state <= ST_DEB;
          end
        end
        ST_DEB: begin
          if (r_key_s != r_cap) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_HOLD;
`ifdef KEYPAD_BCD_MULTI_KEY_ERR_EN
            if (w_multi) begin
              r_err <= 1'b1;
            end else begin
              r_bcd   <= w_code;
              r_valid <= 1'b1;
            end
`else
            r_bcd   <= w_code;
            r_valid <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (r_key_s == '0) begin
            r_cnt   <= '0;
            r_state <= ST_REL;
          end
        end
        ST_REL: begin
          // Any key activity before the release is debounced counts as still held.
          if (r_key_s != '0) begin
            r_state <= ST_HOLD;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Entry register and digit count; clr has priority over a coincident accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digits <= '0;
      r_ndig   <= '0;
    end else if (clr) begin
      r_digits <= '0;
      r_ndig   <= '0;
    end else if (w_accept) begin
      // Left shift drops the oldest digit; also correct for a single-digit register.
      r_digits <= (r_digits << BCD_W) | DIG_W'(w_code);
      if (r_ndig != NDIG_MAX) r_ndig <= r_ndig + NDIG_W'(1);
    end
  end

  assign bcd    = r_bcd;
  assign valid  = r_valid;
  assign digits = r_digits;
  assign ndig   = r_ndig;
  assign busy   = (r_state != ST_IDLE);
`ifdef KEYPAD_BCD_MULTI_KEY_ERR_EN
  assign err    = r_err;
`endif

endmodule
